pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush controller for the 5-stage pipeline.
- Drives the hold (`wr`) and clear (`rst`) inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB segment registers, plus the PC hold.
- Resolves load-use hazards, taken branches, multi-cycle EX operations and data-memory wait.
- Keeps saturating stall and flush event counters for performance debug.

---
 rtl/pipeline_hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush controller for the 5-stage pipeline
module pipeline_hazard_ctrl #(
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_branch_taken,
  input  logic             ex_mc_start,
  input  logic             mem_busy,
  output logic             pc_wr,
  output logic             ifid_wr,
  output logic             idex_wr,
  output logic             exmem_wr,
  output logic             memwb_wr,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             mc_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int MC_W = $clog2(MC_LAT);
  // Start cycle and release cycle are not counted by the down-counter.
  localparam logic [MC_W-1:0] MC_INIT = MC_W'(MC_LAT - 2);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [MC_W-1:0]   mc_cnt_q, mc_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic load_use;
  logic branch_fire;
  logic pc_hold, ifid_hold, idex_hold, exmem_hold;
  logic ifid_clr, idex_clr, exmem_clr, memwb_clr;

  // Load in EX whose result is needed by the instruction in ID.
  assign load_use = ex_memread && (ex_rd != 5'd0) &&
                    ((id_use_rs && (id_rs == ex_rd)) ||
                     (id_use_rt && (id_rt == ex_rd)));

  // Fixed-priority hazard resolution and FSM next-state.
  always_comb begin
    state_d     = state_q;
    mc_cnt_d    = mc_cnt_q;
    branch_fire = 1'b0;
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    idex_hold   = 1'b0;
    exmem_hold  = 1'b0;
    ifid_clr    = 1'b0;
    idex_clr    = 1'b0;
    exmem_clr   = 1'b0;
    memwb_clr   = 1'b0;
    if (mem_busy) begin
      // Whole upstream freezes; a bubble goes into MEM/WB.
      pc_hold    = 1'b1;
      ifid_hold  = 1'b1;
      idex_hold  = 1'b1;
      exmem_hold = 1'b1;
      memwb_clr  = 1'b1;
    end else if (state_q == RUN && ex_mc_start) begin
      pc_hold   = 1'b1;
      ifid_hold = 1'b1;
      idex_hold = 1'b1;
      exmem_clr = 1'b1;
      state_d   = MC_WAIT;
      mc_cnt_d  = MC_INIT;
    end else if (state_q == MC_WAIT && mc_cnt_q != '0) begin
      pc_hold   = 1'b1;
      ifid_hold = 1'b1;
      idex_hold = 1'b1;
      exmem_clr = 1'b1;
      mc_cnt_d  = mc_cnt_q - MC_W'(1);
    end else begin
      // Release cycle of a multi-cycle op behaves like a normal RUN cycle.
      if (state_q == MC_WAIT) begin
        state_d = RUN;
      end
      if (ex_branch_taken) begin
        ifid_clr    = 1'b1;
        idex_clr    = 1'b1;
        branch_fire = 1'b1;
      end else if (load_use) begin
        pc_hold   = 1'b1;
        ifid_hold = 1'b1;
        idex_clr  = 1'b1;
      end
    end
  end

  // Saturating performance counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pc_hold && stall_cnt_q != CNT_MAX) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (branch_fire && flush_cnt_q != CNT_MAX) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // State, multi-cycle counter and performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      mc_cnt_q    <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mc_cnt_q    <= mc_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Controls are gated off while reset is high so segment registers see no stray hold/clear.
  assign pc_wr       = pc_hold    & ~rst;
  assign ifid_wr     = ifid_hold  & ~rst;
  assign idex_wr     = idex_hold  & ~rst;
  assign exmem_wr    = exmem_hold & ~rst;
  assign memwb_wr    = 1'b0;
  assign ifid_flush  = ifid_clr   & ~rst;
  assign idex_flush  = idex_clr   & ~rst;
  assign exmem_flush = exmem_clr  & ~rst;
  assign memwb_flush = memwb_clr  & ~rst;
  assign mc_busy     = (state_q == MC_WAIT) & ~rst;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  localparam int MC_LAT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic       id_use_rs, id_use_rt, ex_memread, ex_branch_taken, ex_mc_start, mem_busy;

  logic pc_wr_a, ifid_wr_a, idex_wr_a, exmem_wr_a, memwb_wr_a;
  logic ifid_flush_a, idex_flush_a, exmem_flush_a, memwb_flush_a, mc_busy_a;
  logic [31:0] stall_a, flush_a;
  logic pc_wr_b, ifid_wr_b, idex_wr_b, exmem_wr_b, memwb_wr_b;
  logic ifid_flush_b, idex_flush_b, exmem_flush_b, memwb_flush_b, mc_busy_b;
  logic [3:0] stall_b, flush_b;

  pipeline_hazard_ctrl #(.MC_LAT(MC_LAT), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .ex_rd(ex_rd), .ex_memread(ex_memread),
    .ex_branch_taken(ex_branch_taken), .ex_mc_start(ex_mc_start), .mem_busy(mem_busy),
    .pc_wr(pc_wr_a), .ifid_wr(ifid_wr_a), .idex_wr(idex_wr_a), .exmem_wr(exmem_wr_a),
    .memwb_wr(memwb_wr_a), .ifid_flush(ifid_flush_a), .idex_flush(idex_flush_a),
    .exmem_flush(exmem_flush_a), .memwb_flush(memwb_flush_a), .mc_busy(mc_busy_a),
    .stall_cnt(stall_a), .flush_cnt(flush_a)
  );

  pipeline_hazard_ctrl #(.MC_LAT(MC_LAT), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .ex_rd(ex_rd), .ex_memread(ex_memread),
    .ex_branch_taken(ex_branch_taken), .ex_mc_start(ex_mc_start), .mem_busy(mem_busy),
    .pc_wr(pc_wr_b), .ifid_wr(ifid_wr_b), .idex_wr(idex_wr_b), .exmem_wr(exmem_wr_b),
    .memwb_wr(memwb_wr_b), .ifid_flush(ifid_flush_b), .idex_flush(idex_flush_b),
    .exmem_flush(exmem_flush_b), .memwb_flush(memwb_flush_b), .mc_busy(mc_busy_b),
    .stall_cnt(stall_b), .flush_cnt(flush_b)
  );

  // Bit order: pc, ifid, idex, exmem, memwb holds; ifid, idex, exmem, memwb flushes; mc_busy
  logic [9:0] out_a, out_b;
  assign out_a = {pc_wr_a, ifid_wr_a, idex_wr_a, exmem_wr_a, memwb_wr_a,
                  ifid_flush_a, idex_flush_a, exmem_flush_a, memwb_flush_a, mc_busy_a};
  assign out_b = {pc_wr_b, ifid_wr_b, idex_wr_b, exmem_wr_b, memwb_wr_b,
                  ifid_flush_b, idex_flush_b, exmem_flush_b, memwb_flush_b, mc_busy_b};

  localparam logic [9:0] E_LU    = 10'b1100001000;
  localparam logic [9:0] E_BR    = 10'b0000011000;
  localparam logic [9:0] E_MCST  = 10'b1110000100;
  localparam logic [9:0] E_MCH   = 10'b1110000101;
  localparam logic [9:0] E_REL   = 10'b0000000001;
  localparam logic [9:0] E_MBW   = 10'b1111000011;
  localparam logic [9:0] E_MBR   = 10'b1111000010;
  localparam logic [9:0] E_RELBR = 10'b0000011001;

  typedef struct {
    logic [4:0] rs, rt, rd;
    logic       urs, urt, mr, br, mc, busy;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl[$];
  int n_checks = 0;
  int n_errors = 0;

  // Reference model: cycles the multi-cycle op still spends in EX, and event totals.
  int mc_left  = 0;
  int st_total = 0;
  int fl_total = 0;

  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                              input logic urt, input logic [4:0] rd, input logic mr,
                              input logic br, input logic mc, input logic busy,
                              input logic [9:0] exp);
    vec_t v;
    v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.rd = rd;
    v.mr = mr; v.br = br; v.mc = mc; v.busy = busy; v.exp = exp;
    return v;
  endfunction

  function automatic int sat15(input int x);
    return (x > 15) ? 15 : x;
  endfunction

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    id_rs = v.rs; id_rt = v.rt; id_use_rs = v.urs; id_use_rt = v.urt; ex_rd = v.rd;
    ex_memread = v.mr; ex_branch_taken = v.br; ex_mc_start = v.mc; mem_busy = v.busy;
  endtask

  // Apply one cycle of inputs, check against the model (and the table entry if given).
  task automatic apply(input vec_t v, input bit use_tbl);
    logic [9:0] e;
    int         nl;
    bit         lu;
    bit         fire;
    drive(v);
    @(negedge clk);
    lu   = v.mr && (v.rd != 0) && ((v.urs && v.rs == v.rd) || (v.urt && v.rt == v.rd));
    e    = '0;
    fire = 0;
    nl   = mc_left;
    if (v.busy) begin
      e = E_MBR;
    end else if (mc_left == 0 && v.mc) begin
      e  = E_MCST;
      nl = MC_LAT - 1;
    end else if (mc_left > 1) begin
      e  = E_MCST;
      nl = mc_left - 1;
    end else begin
      nl = 0;
      if (v.br) begin
        e    = E_BR;
        fire = 1;
      end else if (lu) begin
        e = E_LU;
      end
    end
    e[0] = (mc_left > 0);
    check("out_model", {54'd0, out_a}, {54'd0, e});
    check("out_cnt4", {54'd0, out_b}, {54'd0, e});
    if (use_tbl) check("out_table", {54'd0, out_a}, {54'd0, v.exp});
    check("stall_cnt", {32'd0, stall_a}, 64'(st_total));
    check("flush_cnt", {32'd0, flush_a}, 64'(fl_total));
    check("stall_cnt4", {60'd0, stall_b}, 64'(sat15(st_total)));
    check("flush_cnt4", {60'd0, flush_b}, 64'(sat15(fl_total)));
    @(posedge clk);
    mc_left = nl;
    if (e[9]) st_total++;
    if (fire) fl_total++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    check("rst_outputs", {54'd0, out_a}, 64'd0);
    @(negedge clk);
    check("rst_stall", {32'd0, stall_a}, 64'd0);
    check("rst_flush", {32'd0, flush_a}, 64'd0);
    mc_left = 0; st_total = 0; fl_total = 0;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    do_reset();

    // Load-use then branch over load-use: counter values.
    apply(mk(5, 0, 1, 0, 5, 1, 0, 0, 0, E_LU), 1);
    check("tp1_stall", {32'd0, stall_a}, 64'd1);
    apply(mk(5, 0, 1, 0, 5, 1, 1, 0, 0, E_BR), 1);
    check("tp2_flush", {32'd0, flush_a}, 64'd1);
    check("tp2_stall", {32'd0, stall_a}, 64'd1);

    // Directed table from reset.
    tbl.push_back(mk(5, 0, 1, 0, 5, 1, 0, 0, 0, E_LU));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 10'd0));
    tbl.push_back(mk(0, 7, 0, 1, 7, 1, 0, 0, 0, E_LU));
    tbl.push_back(mk(9, 0, 0, 0, 9, 1, 0, 0, 0, 10'd0));
    tbl.push_back(mk(9, 0, 1, 0, 9, 0, 0, 0, 0, 10'd0));
    tbl.push_back(mk(5, 0, 1, 0, 5, 1, 1, 0, 0, E_BR));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, E_MBR));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, E_MCST));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, E_MCH));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, E_MCH));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, E_REL));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 10'd0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, E_MCST));
    tbl.push_back(mk(5, 0, 1, 0, 5, 1, 0, 0, 0, E_MCH));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, E_MBW));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, E_MBW));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, E_MCH));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, E_RELBR));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 10'd0));
    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], 1);
    end
    // 1 LU + 1 LU + 1 busy + 3 MC + 5 (MC with mem wait) stalled cycles; 2 branch flushes.
    check("table_stall", {32'd0, stall_a}, 64'd11);
    check("table_flush", {32'd0, flush_a}, 64'd2);

    // Asynchronous reset in the middle of MC_WAIT.
    do_reset();
    apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, E_MCST), 1);
    #2;
    check("async_pre_busy", {63'd0, mc_busy_a}, 64'd1);
    check("async_pre_hold", {63'd0, pc_wr_a}, 64'd1);
    rst = 1'b1;
    #1;
    check("async_outputs", {54'd0, out_a}, 64'd0);
    check("async_stall", {32'd0, stall_a}, 64'd0);
    @(negedge clk);
    mc_left = 0; st_total = 0; fl_total = 0;
    rst = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 10'd0), 1);

    // Saturation of the 4-bit counters.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      apply(mk(3, 0, 1, 0, 3, 1, 0, 0, 0, E_LU), 1);
    end
    check("sat_cnt4", {60'd0, stall_b}, 64'd15);
    check("sat_cnt32", {32'd0, stall_a}, 64'd20);

    // Randomised traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      v.rs   = 5'($urandom_range(0, 3));
      v.rt   = 5'($urandom_range(0, 3));
      v.rd   = 5'($urandom_range(0, 3));
      v.urs  = 1'($urandom_range(0, 1));
      v.urt  = 1'($urandom_range(0, 1));
      v.mr   = 1'($urandom_range(0, 1));
      v.br   = ($urandom_range(0, 5) == 0);
      v.mc   = ($urandom_range(0, 7) == 0);
      v.busy = ($urandom_range(0, 5) == 0);
      v.exp  = '0;
      apply(v, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
